pipe_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage MIPS pipeline. Merges the load-use stall request, ID-stage control transfers, a multi-cycle multiply/divide unit (MDU) and a variable-latency data memory into one set of per-stage register enables and flushes. Sequences the MDU through a cycle counter and tracks memory wait cycles. Sits beside the hazard unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_mdu_seq.sv | 62 ++++++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and widths for the pipeline stall/flush scheduler.
package pipe_ctrl_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_J   = 2'b10;
   localparam logic [1:0] PCSRC_JR  = 2'b11;

   typedef enum logic {
      M_IDLE = 1'b0,
      M_BUSY = 1'b1
   } mdu_state_t;

   localparam int MDU_CNT_W  = 6;
   localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/pipe_ctrl_mdu_seq.sv
// MDU sequencer: start pulse, countdown of the operation latency, busy/done decodes.
module mdu_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_is_div,
   output logic o_start,
   output logic o_busy,
   output logic o_done,
   output logic o_state
);

   localparam logic [MDU_CNT_W-1:0] MUL_LOAD = MDU_CNT_W'(MUL_CYCLES - 1);
   localparam logic [MDU_CNT_W-1:0] DIV_LOAD = MDU_CNT_W'(DIV_CYCLES - 1);

   mdu_state_t             r_state;
   mdu_state_t             w_next_state;
   logic [MDU_CNT_W-1:0]   r_cnt;
   logic [MDU_CNT_W-1:0]   w_next_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= M_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         M_IDLE: begin
            if (i_start) begin
               w_next_state = M_BUSY;
               w_next_cnt   = i_is_div ? DIV_LOAD : MUL_LOAD;
            end
         end
         M_BUSY: begin
            // The count keeps running through memory freezes.
            if (r_cnt == '0) w_next_state = M_IDLE;
            else             w_next_cnt   = r_cnt - 1'b1;
         end
         default: w_next_state = M_IDLE;
      endcase
   end

   always_comb begin
      o_start = !reset && (r_state == M_IDLE) && i_start;
      o_busy  = !reset && (r_state == M_BUSY);
      o_done  = !reset && (r_state == M_BUSY) && (r_cnt == '0);
      o_state = r_state;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Per-stage enables/flushes from load-use stall, control transfers, MDU and data-memory waits.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES  = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Stall,
   input  logic [1:0] ID_PCSrc,
   input  logic       ID_MduUse,
   input  logic       EX_MduStart,
   input  logic       EX_MduIsDiv,
   input  logic       MEM_Req,
   input  logic       MEM_Ready,
   output logic       PC_En,
   output logic       IFID_En,
   output logic       IDEX_En,
   output logic       EXMEM_En,
   output logic       IFID_Flush,
   output logic       IDEX_Flush,
   output logic       MEMWB_Flush,
   output logic       Mdu_Start,
   output logic       Mdu_Busy,
   output logic       Mdu_Done,
   output logic       Mem_Timeout,
   output logic       o_dbg_mdu_state
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

   logic                  w_freeze;
   logic                  w_mdu_hazard;
   logic                  w_mdu_req;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic [WAIT_CNT_W-1:0] w_wait_next;
   logic                  r_timeout;

   assign w_freeze     = MEM_Req && !MEM_Ready;
   assign w_mdu_hazard = ID_MduUse && (Mdu_Busy || EX_MduStart);
   assign w_mdu_req    = EX_MduStart && EXMEM_En;

   mdu_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdu_seq (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_mdu_req),
      .i_is_div (EX_MduIsDiv),
      .o_start  (Mdu_Start),
      .o_busy   (Mdu_Busy),
      .o_done   (Mdu_Done),
      .o_state  (o_dbg_mdu_state)
   );

   // Freeze outranks stalls so a frozen EX instruction is never bubbled.
   always_comb begin
      PC_En       = 1'b1;
      IFID_En     = 1'b1;
      IDEX_En     = 1'b1;
      EXMEM_En    = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      MEMWB_Flush = 1'b0;
      if (reset) begin
         PC_En       = 1'b0;
         IFID_En     = 1'b0;
         IDEX_En     = 1'b0;
         EXMEM_En    = 1'b0;
         IFID_Flush  = 1'b1;
         IDEX_Flush  = 1'b1;
         MEMWB_Flush = 1'b1;
      end else if (w_freeze) begin
         PC_En       = 1'b0;
         IFID_En     = 1'b0;
         IDEX_En     = 1'b0;
         EXMEM_En    = 1'b0;
         MEMWB_Flush = 1'b1;
      end else if (w_mdu_hazard || Stall) begin
         PC_En      = 1'b0;
         IFID_En    = 1'b0;
         IDEX_Flush = 1'b1;
      end else if (ID_PCSrc != PCSRC_SEQ) begin
         IFID_Flush = 1'b1;
      end
   end

   assign w_wait_next = !w_freeze ? '0 :
                        (r_wait_cnt == TIMEOUT_VAL) ? r_wait_cnt : r_wait_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_wait_cnt <= w_wait_next;
         if (w_freeze && (w_wait_next == TIMEOUT_VAL)) r_timeout <= 1'b1;
      end
   end

   assign Mem_Timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and random stimulus for pipe_ctrl, checked every cycle against a behavioural model.
module tb_pipe_ctrl;

   localparam int MUL_C = 4;
   localparam int DIV_C = 32;
   localparam int TO_C  = 255;

   logic       clk = 1'b0;
   logic       reset, Stall, ID_MduUse, EX_MduStart, EX_MduIsDiv, MEM_Req, MEM_Ready;
   logic [1:0] ID_PCSrc;
   logic       PC_En, IFID_En, IDEX_En, EXMEM_En, IFID_Flush, IDEX_Flush, MEMWB_Flush;
   logic       Mdu_Start, Mdu_Busy, Mdu_Done, Mem_Timeout, dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: cycles of MDU work remaining (0 = idle), freeze cycles seen, sticky timeout.
   int m_mdu_left = 0;
   int m_wait     = 0;
   bit m_timeout  = 1'b0;

   logic [11:0] exp_q[$];
   logic [11:0] last_obs;

   pipe_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .MEM_TIMEOUT(TO_C)) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .ID_PCSrc(ID_PCSrc),
      .ID_MduUse(ID_MduUse), .EX_MduStart(EX_MduStart), .EX_MduIsDiv(EX_MduIsDiv),
      .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
      .PC_En(PC_En), .IFID_En(IFID_En), .IDEX_En(IDEX_En), .EXMEM_En(EXMEM_En),
      .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .MEMWB_Flush(MEMWB_Flush),
      .Mdu_Start(Mdu_Start), .Mdu_Busy(Mdu_Busy), .Mdu_Done(Mdu_Done),
      .Mem_Timeout(Mem_Timeout), .o_dbg_mdu_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit rst, input bit stl, input logic [1:0] pcs, input bit use_mdu,
                        input bit mstart, input bit isdiv, input bit req, input bit rdy);
      reset = rst; Stall = stl; ID_PCSrc = pcs; ID_MduUse = use_mdu;
      EX_MduStart = mstart; EX_MduIsDiv = isdiv; MEM_Req = req; MEM_Ready = rdy;
   endtask

   // Layout: dbg, PC, IFID, IDEX, EXMEM, IFIDf, IDEXf, MEMWBf, start, busy, done, timeout
   task automatic model_outputs(output logic [11:0] exp);
      bit freeze, busy, hazard;
      bit pc, ifid, idex, exm, fif, fid, fmw, st;
      freeze = MEM_Req && !MEM_Ready;
      busy   = (m_mdu_left > 0);
      hazard = ID_MduUse && (busy || EX_MduStart);
      {pc, ifid, idex, exm, fif, fid, fmw} = 7'b1111_000;
      if (reset)                {pc, ifid, idex, exm, fif, fid, fmw} = 7'b0000_111;
      else if (freeze)          {pc, ifid, idex, exm, fif, fid, fmw} = 7'b0000_001;
      else if (hazard || Stall) {pc, ifid, idex, exm, fif, fid, fmw} = 7'b0011_010;
      else if (ID_PCSrc != 2'b00) fif = 1'b1;
      st  = !reset && !busy && EX_MduStart && exm;
      exp = {busy, pc, ifid, idex, exm, fif, fid, fmw, st,
             !reset && busy, !reset && (m_mdu_left == 1), m_timeout};
   endtask

   task automatic update_model(input logic [11:0] exp);
      if (reset) begin
         m_mdu_left = 0; m_wait = 0; m_timeout = 1'b0;
      end else begin
         if (m_mdu_left > 0) m_mdu_left--;
         else if (exp[3])    m_mdu_left = EX_MduIsDiv ? DIV_C : MUL_C;
         if (MEM_Req && !MEM_Ready) begin
            if (m_wait < TO_C) m_wait++;
            if (m_wait == TO_C) m_timeout = 1'b1;
         end else begin
            m_wait = 0;
         end
      end
   endtask

   task automatic step(input string tag);
      logic [11:0] exp;
      #3;
      model_outputs(exp);
      exp_q.push_back(exp);
      last_obs = {dbg_state, PC_En, IFID_En, IDEX_En, EXMEM_En, IFID_Flush, IDEX_Flush,
                  MEMWB_Flush, Mdu_Start, Mdu_Busy, Mdu_Done, Mem_Timeout};
      check(tag, last_obs, exp_q.pop_front());
      @(posedge clk);
      update_model(exp);
      #1;
   endtask

   initial begin
      int holds;
      int dones;
      drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      step("reset_a");
      step("reset_b");

      drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
      step("idle_after_reset");

      drive(0, 1, 2'b01, 0, 0, 0, 0, 0);
      step("stall_over_branch");
      drive(0, 0, 2'b01, 0, 0, 0, 0, 0);
      step("branch_after_stall");
      drive(0, 0, 2'b11, 0, 0, 0, 0, 0);
      step("jr_flush");

      // Multiply with a dependent HI/LO reader held in ID.
      drive(0, 0, 2'b00, 1, 1, 0, 0, 0);
      step("mult_start");
      holds = 1;
      drive(0, 0, 2'b00, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step("mult_hold");
         if (last_obs[10]) break;
         holds++;
      end
      tests_run++;
      assert (holds == 5) else begin
         tests_failed++;
         $error("FAIL mult_hold_cycles observed=%0d expected=%0d", holds, 5);
      end

      // Divide aborted by reset: no done pulse may follow.
      drive(0, 0, 2'b00, 0, 1, 1, 0, 0);
      step("div_start");
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step("div_busy");
      drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
      step("div_reset");
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         step("div_aborted");
         if (last_obs[1]) dones++;
      end
      tests_run++;
      assert (dones == 0) else begin
         tests_failed++;
         $error("FAIL div_abort_done observed=%0d expected=%0d", dones, 0);
      end

      // Short memory wait, with stall and MDU hazard overlapping the freeze.
      drive(0, 1, 2'b01, 1, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) step("mem_freeze");
      drive(0, 0, 2'b00, 0, 0, 0, 1, 1);
      step("mem_ready");
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
      step("mem_after");

      // Long memory wait through the timeout.
      drive(0, 0, 2'b00, 0, 0, 0, 1, 0);
      for (int i = 0; i < 300; i++) step("mem_timeout_wait");
      drive(0, 0, 2'b00, 0, 0, 0, 1, 1);
      step("mem_timeout_done");
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("timeout_sticky");
      tests_run++;
      assert (Mem_Timeout === 1'b1) else begin
         tests_failed++;
         $error("FAIL timeout_sticky_direct observed=%b expected=%b", Mem_Timeout, 1'b1);
      end
      drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
      step("timeout_reset");
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
      step("timeout_cleared");

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20, 2'($urandom_range(0, 3)),
               $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15, $urandom_range(0, 1) == 1,
               $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60);
         step("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
